receiver_ctrl: RTL and testbench
================================

// Module: receiver_ctrl
// PURPOSE
// Consumer stage directly downstream of the memory sender. Accepts one 16-word frame over the
// four-phase Req/Ack handshake (data on DataIn while Req high), writes each word into a
// 16-deep destination memory (Address/DataWrite/WriteEnable), then pulses Done for 2 cycles.
// Sits between the sender's data/Req outputs and the destination RAM write port.
// PARAMETERS
// DATA_WIDTH  16  width of DataIn/DataWrite
// ADDR_WIDTH  4   width of Address; frame length DEPTH = 2**ADDR_WIDTH = 16 words
// SYNC_REQ    0   1: Req passes a 2-flop synchronizer before use; 0: Req used directly
// PORTS
// Clock      in   1           single system clock, all state on rising edge
// Reset      in   1           asynchronous, active-low reset (0 = reset)
// Receive    in   1           start request; sampled only in IDLE
// Req        in   1           sender request; DataIn valid while high
// DataIn     in   DATA_WIDTH  word from sender
// Ack        out  1           handshake acknowledge, registered
// WriteEnable out 1           destination RAM write strobe, registered, 1-cycle pulse
// Address    out  ADDR_WIDTH  destination RAM address = current word index
// DataWrite  out  DATA_WIDTH  captured word presented to RAM
// Busy       out  1           high in every state except IDLE
// Done       out  1           frame complete, high exactly 2 cycles
// BEHAVIOUR
// - Reset low (any time, incl. mid-frame): state IDLE; Ack, WriteEnable, Done, Busy = 0;
//   Address = 0; DataWrite = 0; synchronizer flops = 0. Partial frame discarded, no resume.
// - req_s = Req (SYNC_REQ=0) or Req delayed 2 cycles (SYNC_REQ=1). All decisions use req_s.
// - States: IDLE, WAIT_REQ, WRITE, ACK, DONE1, DONE2 (all outputs registered).
// - IDLE: Receive=1 -> WAIT_REQ, Address<=0, Busy<=1. Else stay.
// - WAIT_REQ: req_s=1 -> WRITE; same edge DataWrite<=DataIn, WriteEnable<=1. Else stay.
//   req_s already high on entry is accepted immediately (no edge detection).
// - WRITE (1 cycle): WriteEnable<=0, Ack<=1 -> ACK. RAM writes DataWrite@Address at this edge.
//   Latency (SYNC_REQ=0): Req seen at edge k -> WE high k..k+1 -> Ack rises at edge k+1.
// - ACK: hold Ack=1 until req_s=0; then Ack<=0 and
//     Address==DEPTH-1 -> Address<=0 (wrap), Done<=1 -> DONE1;
//     else Address<=Address+1 -> WAIT_REQ.
// - DONE1 -> DONE2 (Done stays 1) -> IDLE with Done<=0, Busy<=0.
// - Receive ignored outside IDLE (asserting/deasserting mid-frame has no effect).
//   Receive high while returning to IDLE starts a new frame next cycle.
// - Req toggling in WRITE is ignored; Req dropping before Ack rises does not abort:
//   Ack still rises for one cycle, then ACK sees req_s=0 and completes the word.
// - Address never exceeds DEPTH-1; exactly DEPTH writes per frame, one per handshake.
// - Ack is never high in IDLE, WAIT_REQ, WRITE, DONE1, DONE2.
// TESTING
// 1 Full frame: Reset release, Receive=1, model sender sends 16'h0000..16'h000F -> 16 WE
//   pulses at Address 0..15 with matching DataWrite, Ack 16 rising edges, Done high 2 cycles,
//   Busy low afterwards, Address=0.
// 2 Latency (SYNC_REQ=0): Req high at edge k with DataIn=16'hA5A5 -> DataWrite=16'hA5A5 and
//   WE=1 after k, Ack=1 after k+1; SYNC_REQ=1 -> both shifted by exactly 2 cycles.
// 3 Reset mid-frame: Reset low during 6th word's ACK -> all outputs 0 immediately (async);
//   new Receive after release restarts at Address 0, 16 words required for Done.
// 4 Req held high on entry to WAIT_REQ (back-to-back sender) -> word captured on first
//   cycle in WAIT_REQ; no lost or duplicated writes across the frame.
// 5 Receive pulsed/dropped mid-frame and held high during DONE -> frame unaffected; second
//   frame starts the cycle after returning to IDLE.
// 6 Sender stall: Req held high 10 cycles after Ack -> Ack stays 1, no extra WE, Address
//   unchanged until Req falls, then increments by exactly 1.

Source files
------------

// File: rtl/receiver_ctrl.sv
// receiver_ctrl: four-phase Req/Ack frame receiver writing DEPTH words into a destination RAM.
module receiver_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter bit SYNC_REQ   = 1'b0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Receive,
  input  logic                  Req,
  input  logic [DATA_WIDTH-1:0] DataIn,
  output logic                  Ack,
  output logic                  WriteEnable,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] DataWrite,
  output logic                  Busy,
  output logic                  Done
);
  typedef enum logic [2:0] {IDLE, WAIT_REQ, WRITE, ACK, DONE1, DONE2} state_t;
  state_t                state_q, state_d;
  logic [1:0]            sync_q, sync_d;
  logic                  ack_q, ack_d, we_q, we_d, busy_q, busy_d, done_q, done_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  req_s;
  assign req_s = SYNC_REQ ? sync_q[1] : Req;
  always_comb begin
    sync_d  = {sync_q[0], Req};
    state_d = state_q;
    ack_d   = ack_q;
    we_d    = we_q;
    busy_d  = busy_q;
    done_d  = done_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: if (Receive) begin
        state_d = WAIT_REQ;
        addr_d  = '0;
        busy_d  = 1'b1;
      end
      WAIT_REQ: if (req_s) begin
        state_d = WRITE;
        data_d  = DataIn;
        we_d    = 1'b1;
      end
      WRITE: begin
        state_d = ACK;
        we_d    = 1'b0;
        ack_d   = 1'b1;
      end
      ACK: if (!req_s) begin
        ack_d   = 1'b0;
        state_d = (&addr_q) ? DONE1 : WAIT_REQ;
        done_d  = &addr_q;
        addr_d  = (&addr_q) ? '0 : addr_q + ADDR_WIDTH'(1);
      end
      DONE1: state_d = DONE2;
      DONE2: begin
        state_d = IDLE;
        done_d  = 1'b0;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      sync_q  <= '0;
      ack_q   <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      ack_q   <= ack_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end
  assign Ack         = ack_q;
  assign WriteEnable = we_q;
  assign Busy        = busy_q;
  assign Done        = done_q;
  assign Address     = addr_q;
  assign DataWrite   = data_q;
endmodule

// File: tb/tb_receiver_ctrl.sv
// tb_receiver_ctrl: directed frames with a write scoreboard for receiver_ctrl (direct and synchronized Req).
module tb_receiver_ctrl;
  logic        Clock = 1'b0, Reset = 1'b0, Receive = 1'b0, Req = 1'b0;
  logic [15:0] DataIn = '0;
  logic        Ack, WriteEnable, Busy, Done;
  logic [3:0]  Address;
  logic [15:0] DataWrite;
  logic        rcv2 = 1'b0, req2 = 1'b0;
  logic        ack2, we2, busy2, done2;
  logic [3:0]  addr2;
  logic [15:0] dw2;
  int          vectors = 0, errors = 0, we_cnt = 0, ack_rise = 0;
  logic        ack_prev = 1'b0;
  logic [19:0] sb[$];
  always #5 Clock = ~Clock;
  receiver_ctrl u_dut (
    .Clock(Clock), .Reset(Reset), .Receive(Receive), .Req(Req), .DataIn(DataIn),
    .Ack(Ack), .WriteEnable(WriteEnable), .Address(Address), .DataWrite(DataWrite),
    .Busy(Busy), .Done(Done)
  );
  receiver_ctrl #(.SYNC_REQ(1'b1)) u_sync (
    .Clock(Clock), .Reset(Reset), .Receive(rcv2), .Req(req2), .DataIn(DataIn),
    .Ack(ack2), .WriteEnable(we2), .Address(addr2), .DataWrite(dw2),
    .Busy(busy2), .Done(done2)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Every write strobe must match the oldest word the sender has offered.
  always @(negedge Clock) if (Reset) begin
    if (WriteEnable === 1'b1) begin
      we_cnt++;
      if (sb.size() == 0) check("extra_we", 1, 0);
      else begin
        logic [19:0] e;
        e = sb.pop_front();
        check("we_addr", Address, e[19:16]);
        check("we_data", DataWrite, e[15:0]);
      end
    end
    if (Ack === 1'b1 && !ack_prev) ack_rise++;
    ack_prev = Ack;
    check("ack_we_excl", Ack & WriteEnable, 0);
    check("ack_not_idle", Ack & ~Busy, 0);
  end
  task automatic wait_ack(input logic v, input string tag);
    for (int i = 0; i < 40; i++) begin
      @(negedge Clock);
      if (Ack === v) break;
    end
    check(tag, Ack, v);
  endtask
  task automatic send_word(input int w, input logic [15:0] d, input int stall);
    DataIn = d;
    Req = 1'b1;
    sb.push_back({4'(w), d});
    wait_ack(1'b1, "ack_rise");
    repeat (stall) begin
      @(negedge Clock);
      check("stall_ack", Ack, 1);
      check("stall_addr", Address, w);
    end
    Req = 1'b0;
    wait_ack(1'b0, "ack_fall");
    check("addr_next", Address, (w + 1) % 16);
  endtask
  task automatic run_frame(input logic [15:0] base, input int first, input int stall_w,
                           input bit glitch, input bit hold_end, input bit start);
    int w0, a0;
    if (start) begin
      @(negedge Clock) Receive = 1'b1;
      @(negedge Clock) Receive = 1'b0;
    end
    check("busy_start", Busy, 1);
    check("addr_start", Address, first);
    w0 = we_cnt;
    a0 = ack_rise;
    for (int w = first; w < 16; w++) begin
      if (glitch && w == 3) Receive = 1'b1;
      if (glitch && w == 6) Receive = 1'b0;
      if (hold_end && w == 15) Receive = 1'b1;
      send_word(w, base + 16'(w), (w == stall_w) ? 10 : 0);
    end
    check("done_c1", Done, 1);
    @(negedge Clock);
    check("done_c2", Done, 1);
    check("busy_done", Busy, 1);
    @(negedge Clock);
    check("done_end", Done, 0);
    check("busy_end", Busy, 0);
    check("addr_end", Address, 0);
    check("we_count", we_cnt - w0, 16 - first);
    check("ack_count", ack_rise - a0, 16 - first);
    check("sb_empty", sb.size(), 0);
    if (hold_end) begin
      @(negedge Clock);
      check("restart_busy", Busy, 1);
      Receive = 1'b0;
    end
  endtask
  initial begin
    repeat (2) @(negedge Clock);
    check("rst_outs", {Ack, WriteEnable, Busy, Done, Address, DataWrite}, 0);
    check("rst_outs_sync", {ack2, we2, busy2, done2, addr2, dw2}, 0);
    Reset = 1'b1;
    @(negedge Clock);
    check("idle_busy", Busy, 0);
    // Synchronized Req: same handshake shifted by two cycles.
    DataIn = 16'hA5A5;
    rcv2 = 1'b1;
    @(negedge Clock) rcv2 = 1'b0;
    req2 = 1'b1;
    @(negedge Clock) check("sync_we_k", we2, 0);
    @(negedge Clock) check("sync_we_k1", we2, 0);
    @(negedge Clock);
    check("sync_we_k2", we2, 1);
    check("sync_dw_k2", dw2, 16'hA5A5);
    check("sync_ack_k2", ack2, 0);
    @(negedge Clock) check("sync_ack_k3", ack2, 1);
    req2 = 1'b0;
    // Direct Req latency on word 0, then the rest of the frame.
    Receive = 1'b1;
    @(negedge Clock) Receive = 1'b0;
    Req = 1'b1;
    sb.push_back({4'd0, 16'hA5A5});
    @(negedge Clock);
    check("lat_we_k", WriteEnable, 1);
    check("lat_dw_k", DataWrite, 16'hA5A5);
    check("lat_ack_k", Ack, 0);
    @(negedge Clock);
    check("lat_ack_k1", Ack, 1);
    check("lat_we_k1", WriteEnable, 0);
    Req = 1'b0;
    wait_ack(1'b0, "lat_ack_fall");
    run_frame(16'h0000, 1, -1, 1'b0, 1'b0, 1'b0);
    run_frame(16'h0000, 0, 7, 1'b0, 1'b0, 1'b1);
    // Reset while the 6th word sits in ACK.
    @(negedge Clock) Receive = 1'b1;
    @(negedge Clock) Receive = 1'b0;
    for (int w = 0; w < 5; w++) send_word(w, 16'h0100 + 16'(w), 0);
    DataIn = 16'h0105;
    Req = 1'b1;
    sb.push_back({4'd5, 16'h0105});
    wait_ack(1'b1, "rst_ack_rise");
    @(posedge Clock);
    #3 Reset = 1'b0;
    #1 check("async_rst_outs", {Ack, WriteEnable, Busy, Done, Address, DataWrite}, 0);
    check("rst_sb_empty", sb.size(), 0);
    Req = 1'b0;
    @(negedge Clock) Reset = 1'b1;
    @(negedge Clock) check("post_rst_idle", Busy, 0);
    run_frame(16'h0200, 0, -1, 1'b0, 1'b0, 1'b1);
    run_frame(16'h0300, 0, -1, 1'b1, 1'b1, 1'b1);
    run_frame(16'h0400, 0, -1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge Clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
